mem_port_arbiter: RTL

//  - Shares one 128-bit line-granular memory port between the read-only I-cache and the read/write D-cache.
//  - Sits between both cache controllers and external memory.
//  - Arbitrates requests, latches the granted transaction, drives memory from registers.
//  - Routes mem_ready back to the owner only.
//  - Watchdog flags a memory transaction that never completes.

---
 rtl/mem_port_arbiter.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares one line-granular memory port between the read-only I-cache and the
// read/write D-cache. A request seen in IDLE is arbitrated, the winning
// transaction is latched into registers that drive the memory port, and the
// memory's completion is routed back to the owner only. A watchdog flags a
// transaction that never completes.
//
// Ports
//   clk, proc_reset           clock and synchronous active-high reset
//   ic_mem_read/addr          I-cache line read request (held until ready)
//   ic_mem_rdata/ready        I-cache read line and one-cycle completion
//   dc_mem_read/write/addr    D-cache request (held until ready)
//   dc_mem_wdata              D-cache write-back line
//   dc_mem_rdata/ready        D-cache read line and one-cycle completion
//   mem_read/write/addr/wdata registered memory request
//   mem_rdata/ready           memory read line and completion pulse
//   err_timeout               sticky watchdog flag
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
    parameter int ADDR_W  = 28,
    parameter int LINE_W  = 128,
    parameter int RR_EN   = 1,
    parameter int TIMEOUT = 1023
) (
    input  logic              clk,
    input  logic              proc_reset,
    input  logic              ic_mem_read,
    input  logic [ADDR_W-1:0] ic_mem_addr,
    output logic [LINE_W-1:0] ic_mem_rdata,
    output logic              ic_mem_ready,
    input  logic              dc_mem_read,
    input  logic              dc_mem_write,
    input  logic [ADDR_W-1:0] dc_mem_addr,
    input  logic [LINE_W-1:0] dc_mem_wdata,
    output logic [LINE_W-1:0] dc_mem_rdata,
    output logic              dc_mem_ready,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [LINE_W-1:0] mem_wdata,
    input  logic [LINE_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic              err_timeout
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_IC_BUSY = 2'd1;
    localparam logic [1:0] ST_DC_BUSY = 2'd2;

    localparam logic GRANT_IC = 1'b0;
    localparam logic GRANT_DC = 1'b1;

    logic [1:0]        state_reg, state_next;
    logic              last_grant_reg, last_grant_next;
    logic              mem_read_reg, mem_read_next;
    logic              mem_write_reg, mem_write_next;
    logic [ADDR_W-1:0] mem_addr_reg, mem_addr_next;
    logic [LINE_W-1:0] mem_wdata_reg, mem_wdata_next;

    logic ic_req;
    logic dc_req;
    logic grant_dc;

    assign ic_req = ic_mem_read;
    assign dc_req = dc_mem_read | dc_mem_write;

    // On a tie, round-robin hands the port to whoever did not win last time;
    // otherwise the D-cache always wins.
    always_comb begin
        if (ic_req && dc_req) begin
            grant_dc = (RR_EN != 0) ? (last_grant_reg == GRANT_IC) : 1'b1;
        end else begin
            grant_dc = dc_req;
        end
    end

    always_comb begin
        state_next      = state_reg;
        last_grant_next = last_grant_reg;
        mem_read_next   = mem_read_reg;
        mem_write_next  = mem_write_reg;
        mem_addr_next   = mem_addr_reg;
        mem_wdata_next  = mem_wdata_reg;
        case (state_reg)
            ST_IDLE: begin
                if (ic_req || dc_req) begin
                    last_grant_next = grant_dc;
                    if (grant_dc) begin
                        // read+write together is a write-back
                        mem_write_next = dc_mem_write;
                        mem_read_next  = ~dc_mem_write;
                        mem_addr_next  = dc_mem_addr;
                        mem_wdata_next = dc_mem_wdata;
                        state_next     = ST_DC_BUSY;
                    end else begin
                        mem_write_next = 1'b0;
                        mem_read_next  = 1'b1;
                        mem_addr_next  = ic_mem_addr;
                        state_next     = ST_IC_BUSY;
                    end
                end
            end
            ST_IC_BUSY, ST_DC_BUSY: begin
                // Returning to IDLE guarantees one idle cycle, so a requester
                // that dropped its request on ready is never served twice.
                if (mem_ready) begin
                    mem_read_next  = 1'b0;
                    mem_write_next = 1'b0;
                    state_next     = ST_IDLE;
                end
            end
            default: begin
                mem_read_next  = 1'b0;
                mem_write_next = 1'b0;
                state_next     = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (proc_reset) begin
            state_reg      <= ST_IDLE;
            last_grant_reg <= GRANT_IC;
            mem_read_reg   <= 1'b0;
            mem_write_reg  <= 1'b0;
            mem_addr_reg   <= '0;
            mem_wdata_reg  <= '0;
        end else begin
            state_reg      <= state_next;
            last_grant_reg <= last_grant_next;
            mem_read_reg   <= mem_read_next;
            mem_write_reg  <= mem_write_next;
            mem_addr_reg   <= mem_addr_next;
            mem_wdata_reg  <= mem_wdata_next;
        end
    end

    assign mem_read     = mem_read_reg;
    assign mem_write    = mem_write_reg;
    assign mem_addr     = mem_addr_reg;
    assign mem_wdata    = mem_wdata_reg;
    assign ic_mem_rdata = mem_rdata;
    assign dc_mem_rdata = mem_rdata;
    // mem_ready outside a BUSY state is dropped here.
    assign ic_mem_ready = mem_ready && (state_reg == ST_IC_BUSY);
    assign dc_mem_ready = mem_ready && (state_reg == ST_DC_BUSY);

    // Watchdog: counts BUSY cycles without completion. The flag rises on the
    // edge where the count reaches TIMEOUT; the count then saturates and the
    // transaction keeps waiting.
    generate
        if (TIMEOUT > 0) begin : g_wd
            localparam int              WD_W   = $clog2(TIMEOUT + 1);
            localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT);

            logic [WD_W-1:0] wd_cnt_reg, wd_cnt_next;
            logic            err_timeout_reg, err_timeout_next;

            always_comb begin
                wd_cnt_next      = wd_cnt_reg;
                err_timeout_next = err_timeout_reg;
                if (state_reg == ST_IDLE) begin
                    wd_cnt_next = '0;
                end else if (!mem_ready && (wd_cnt_reg != WD_MAX)) begin
                    wd_cnt_next = wd_cnt_reg + 1'b1;
                    if (wd_cnt_reg == (WD_MAX - 1'b1)) begin
                        err_timeout_next = 1'b1;
                    end
                end
            end

            always_ff @(posedge clk) begin
                if (proc_reset) begin
                    wd_cnt_reg      <= '0;
                    err_timeout_reg <= 1'b0;
                end else begin
                    wd_cnt_reg      <= wd_cnt_next;
                    err_timeout_reg <= err_timeout_next;
                end
            end

            assign err_timeout = err_timeout_reg;
        end else begin : g_no_wd
            assign err_timeout = 1'b0;
        end
    endgenerate

endmodule
